// File: rtl/instr_stream_gen_if.sv
// AXI-Stream style instruction bus between the stream generator
// and its consumer.
interface instr_stream_gen_if #(
    parameter int instr_bits = 16
);
    logic [instr_bits-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/instr_stream_gen.sv
// Replays a CPU-loaded instruction program onto a stream bus,
// with backpressure, multi-pass looping, abort and halt signalling.
module instr_stream_gen #(
    parameter int prog_depth = 256,
    parameter int addr_bits  = 8,
    parameter int instr_bits = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_wr_en,
    input  logic [addr_bits-1:0]  prog_wr_addr,
    input  logic [instr_bits-1:0] prog_wr_data,
    input  logic [addr_bits:0]    prog_len,
    input  logic [15:0]           loop_count,
    input  logic                  start,
    input  logic                  abort,
    instr_stream_gen_if.master    instr_axis,
    output logic                  halt,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           words_sent,
    output logic                  wr_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [addr_bits-1:0] ADDR_ONE = 1;
    localparam logic [addr_bits:0]   LEN_ONE  = 1;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_start_d;
    logic [addr_bits:0]    r_len;
    logic [15:0]           r_loops;
    logic [15:0]           r_pass;
    logic [addr_bits-1:0]  r_rd_addr;
    logic [instr_bits-1:0] r_mem [prog_depth];
    logic [instr_bits-1:0] r_rd_data;
    logic                  r_rd_vld;
    logic [instr_bits-1:0] r_sk0;
    logic [instr_bits-1:0] r_sk1;
    logic [1:0]            r_sk_cnt;
    logic [instr_bits-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_halt;
    logic                  r_busy;
    logic                  r_done;
    logic [31:0]           r_words;
    logic                  r_wr_err;

    logic w_start_edge;
    logic w_accept;
    logic w_rd_en;
    logic w_addr_wrap;
    logic w_last_rd;
    logic w_space;
    logic w_hs;
    logic w_out_free;
    logic w_abort;
    logic w_last_hs;
    logic w_finish_in;
    logic w_pop;
    logic w_push;

    assign w_start_edge = start & ~r_start_d;
    assign w_addr_wrap  = ({1'b0, r_rd_addr} == (r_len - LEN_ONE));
    assign w_last_rd    = w_addr_wrap & (r_pass == r_loops);
    // In-flight read plus buffered words must leave room for one more.
    assign w_space      = ({1'b0, r_sk_cnt} + {2'b00, r_rd_vld}) < 3'd2;
    assign w_hs         = r_tvalid & instr_axis.tready;
    assign w_out_free   = ~r_tvalid | instr_axis.tready;
    assign w_abort      = abort &
                          ((r_state == S_STREAM) | (r_state == S_DRAIN));
    assign w_last_hs    = (r_state == S_DRAIN) & w_hs &
                          (r_sk_cnt == 2'd0) & ~r_rd_vld;
    assign w_finish_in  = (w_state_nxt == S_FINISH) &
                          (r_state != S_FINISH);
    assign w_pop        = w_out_free & (r_sk_cnt != 2'd0);
    assign w_push       = r_rd_vld & ((r_sk_cnt != 2'd0) | ~w_out_free);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (prog_len == '0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    w_state_nxt = S_FINISH;
                end else if (w_space) begin
                    w_rd_en = 1'b1;
                    if (w_last_rd) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort || w_last_hs) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_d <= 1'b0;
            r_len     <= '0;
            r_loops   <= '0;
            r_pass    <= '0;
            r_rd_addr <= '0;
            r_halt    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_words   <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_start_d <= start;
            if (w_accept) begin
                r_len     <= prog_len;
                r_loops   <= (loop_count == '0) ? 16'd1 : loop_count;
                r_rd_addr <= '0;
                r_pass    <= 16'd1;
                r_halt    <= 1'b0;
                r_done    <= 1'b0;
                r_busy    <= 1'b1;
            end
            if (w_rd_en) begin
                if (w_addr_wrap) begin
                    r_rd_addr <= '0;
                    r_pass    <= r_pass + 16'd1;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_ONE;
                end
            end
            // Zero-length runs accept and finish on the same edge.
            if (w_finish_in) begin
                r_halt <= 1'b1;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (prog_wr_en && r_busy) begin
                r_wr_err <= 1'b1;
            end
            if (w_accept) begin
                r_words <= '0;
            end else if (w_hs && (r_words != '1)) begin
                r_words <= r_words + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_wr_en && !r_busy) begin
            r_mem[prog_wr_addr] <= prog_wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_vld <= 1'b0;
            r_sk0    <= '0;
            r_sk1    <= '0;
            r_sk_cnt <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else if (w_abort) begin
            r_rd_vld <= 1'b0;
            r_sk_cnt <= '0;
            r_tvalid <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            // Skid words take priority; RAM data bypasses when empty.
            if (w_out_free) begin
                if (r_sk_cnt != 2'd0) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_sk0;
                end else if (r_rd_vld) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_rd_data;
                end else begin
                    r_tvalid <= 1'b0;
                end
            end
            if (w_pop) begin
                r_sk0 <= (r_sk_cnt == 2'd2) ? r_sk1 : r_rd_data;
                r_sk1 <= r_rd_data;
            end else if (w_push) begin
                if (r_sk_cnt == 2'd0) begin
                    r_sk0 <= r_rd_data;
                end else begin
                    r_sk1 <= r_rd_data;
                end
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign instr_axis.tdata  = r_tdata;
    assign instr_axis.tvalid = r_tvalid;
    assign halt              = r_halt;
    assign busy              = r_busy;
    assign done              = r_done;
    assign words_sent        = r_words;
    assign wr_err            = r_wr_err;

endmodule

// File: doc/instr_stream_gen.md
# instr_stream_gen

Instruction-stream transmitter that feeds the experiment FSM's 16-bit instruction AXI-Stream bus and drives its `halt` input. The CPU loads a program into an internal instruction RAM, sets a length and a pass count, and triggers a run. The block then replays the program at up to one word per clock with full backpressure support. After the final word of the final pass is accepted, it raises `halt` so the consumer stops cleanly on buffer empty.

## Interface
- `prog_depth`, 256: instruction RAM words; power of two.
- `addr_bits`, 8: log2(`prog_depth`).
- `instr_bits`, 16: instruction word width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `prog_wr_en` in 1: CPU program write strobe.
- `prog_wr_addr` in `addr_bits`: CPU write address.
- `prog_wr_data` in `instr_bits`: CPU write data.
- `prog_len` in `addr_bits`+1: words per pass, 0..`prog_depth`. Sampled at start.
- `loop_count` in 16: number of passes; 0 is treated as 1. Sampled at start.
- `start` in 1: run trigger, rising-edge detected internally.
- `abort` in 1: level; terminates a run.
- `instr_axis_tdata` out `instr_bits`: instruction word.
- `instr_axis_tvalid` out 1: word valid.
- `instr_axis_tready` in 1: consumer accept.
- `halt` out 1: all words delivered (or aborted).
- `busy` out 1: run in progress.
- `done` out 1: sticky run-complete flag; cleared by the next accepted start.
- `words_sent` out 32: handshakes completed in the current/last run.
- `wr_err` out 1: sticky flag; set when a program write is attempted while `busy`. Cleared only by reset.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Start edge detector register is 0.
  - RAM contents are not reset.
- Program writes take effect only when not `busy`. A write while `busy` is dropped and sets `wr_err`.
- RAM is synchronous-read with 1-cycle latency. A 2-entry prefetch skid buffer sits between the RAM and the output register so throughput holds at 1 word/cycle under continuous `tready`.
- States:
  - IDLE:
    - On a `start` rising edge, latch `prog_len` and `max(loop_count,1)`.
    - Clear `done`, `halt` and `words_sent`; set `busy`.
    - If latched `prog_len`==0, go to FINISH. Otherwise go to STREAM with read address 0 and pass counter 1.
    - `start` edges seen while not in IDLE are ignored.
  - STREAM:
    - Issue RAM reads whenever the skid buffer has space.
    - The read address wraps from `prog_len`-1 to 0 and increments the pass counter.
    - Reads stop after address `prog_len`-1 of the final pass has been issued.
    - Go to DRAIN once that final read is issued.
  - DRAIN: keep presenting buffered words. When the last word handshakes, go to FINISH.
  - FINISH:
    - Set `halt`=1 and `done`=1; clear `busy`; `tvalid`=0.
    - Next cycle go to IDLE. `halt` remains 1 until the next accepted start.
- `abort` in STREAM or DRAIN:
  - Next cycle: `tvalid`=0 and the skid buffer is flushed.
  - Then go to FINISH, setting `halt` and `done`.
  - `abort` in IDLE has no effect.
- `words_sent` increments on every `tvalid & tready` cycle. It saturates at 2^32-1.

## Timing
- AXI-Stream rules:
  - `tdata` is held stable while `tvalid & !tready`.
  - `tvalid` never deasserts without a handshake, except on `abort`.
- Latency:
  - Cycle 0: `start` edge sampled in IDLE.
  - Cycle 1: `busy`=1.
  - Cycle 3: first `tvalid`=1, i.e. RAM read plus output register. This holds with `tready` high.
- With `tready` held high, N = `prog_len` × passes words are delivered on N consecutive cycles, with no bubble at pass wrap.
- `halt` rises exactly 1 cycle after the final handshake, and `tvalid` is 0 in that same cycle. This guarantees the consumer sees `!tvalid && halt` together.
- Simultaneous `abort` and final handshake: the handshake counts, and FINISH is entered normally.
- Reset mid-run: all outputs return to reset values immediately. `words_sent` is lost.

## Test plan
- Load 4 words 0x0001,0x0002,0x0004,0x0080; `prog_len`=4, `loop_count`=3; `tready`=1 → 12 consecutive words 1,2,4,0x80 ×3 from cycle 3; `halt`=`done`=1 one cycle after the 12th word; `words_sent`=12.
- Same program with `tready` toggled 1-0-1-0 and a random pattern → identical word sequence with no drops or duplicates; `tdata` stable on every stalled cycle; `words_sent`=12.
- `prog_len`=0, start → no `tvalid`; `halt`=`done`=1 within 2 cycles; `words_sent`=0.
- `loop_count`=0, `prog_len`=256, `tready`=1 → exactly 256 words, addresses 0..255 in order.
- Assert `abort` after word 5 of a 12-word run → `tvalid`=0 next cycle, `halt`=1; `words_sent`=5; a second start then replays from word 0.
- Write while `busy` → RAM unchanged (verified by the next run's output); `wr_err`=1 persisting until reset. Assert `rst`=0 mid-run → all outputs 0 asynchronously.
